// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared helpers for the polyphase filter blocks
package filt_pkg;

    localparam int COEFF_BITS_MAX = 4096;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ppi_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2_safe(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Sign-extended coefficient h[idx] of a flattened table; zero past the prototype length.
    function automatic logic signed [63:0] coeff_at(
        input logic [COEFF_BITS_MAX-1:0] coeffs,
        input int                        idx,
        input int                        n,
        input int                        w
    );
        logic signed [63:0] r;
        r = '0;
        if (idx < n) begin
            for (int b = 0; b < 64; b++) begin
                r[b] = (b < w) ? coeffs[idx*w + b] : coeffs[idx*w + w - 1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/filt_ppi_phase_mac.sv
// rtl/filt_ppi_phase_mac.sv - combinational sub-filter for one interpolation phase
module filt_ppi_phase_mac
    import filt_pkg::*;
#(
    parameter int gp_idata_width          = 6,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_coeff_length         = 8,
    parameter int gp_coeff_width          = 16,
    parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs = {8{16'sd1}},
    parameter int gp_taps                 = 2,
    parameter int gp_odata_width          = 23,
    parameter int gp_phase_width          = 2
) (
    input  logic        [gp_phase_width-1:0] phase,
    input  logic signed [gp_idata_width-1:0] x_line [gp_taps],
    output logic signed [gp_odata_width-1:0] y
);

    localparam int L  = gp_interpolation_factor;
    localparam int OW = gp_odata_width;
    localparam logic [COEFF_BITS_MAX-1:0] COEFFS_EXT = COEFF_BITS_MAX'(gp_coeffs);

    logic signed [OW-1:0] c_sel;

    // Operands are widened to the output width first so every product and partial sum is exact.
    always_comb begin
        y     = '0;
        c_sel = '0;
        for (int k = 0; k < gp_taps; k++) begin
            c_sel = '0;
            for (int q = 0; q < L; q++) begin
                if (phase == gp_phase_width'(q)) begin
                    c_sel = OW'(coeff_at(COEFFS_EXT, k*L + q, gp_coeff_length, gp_coeff_width));
                end
            end
            y = y + c_sel * OW'(x_line[k]);
        end
    end

endmodule

// File: rtl/filt_ppi.sv
// rtl/filt_ppi.sv - polyphase interpolation FIR, one input in, L phases out back to back
module filt_ppi
    import filt_pkg::*;
#(
    parameter int gp_idata_width          = 6,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_coeff_length         = 8,
    parameter int gp_coeff_width          = 16,
    parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs = {8{16'sd1}},
    parameter bit gp_phase_rev            = 1'b0,
    parameter int gp_odata_width          = gp_idata_width + gp_coeff_width
                                            + $clog2(ceil_div(gp_coeff_length, gp_interpolation_factor))
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic signed [gp_idata_width-1:0]           i_data,
    output logic                                       o_valid,
    output logic signed [gp_odata_width-1:0]           o_data,
    output logic [$clog2(gp_interpolation_factor)-1:0] o_phase,
    output logic                                       o_sclk
);

    localparam int L  = gp_interpolation_factor;
    localparam int T  = ceil_div(gp_coeff_length, L);
    localparam int PW = $clog2(L);

    generate
        if (L < 2) begin : g_bad_factor
            $error("filt_ppi: gp_interpolation_factor must be at least 2");
        end
    endgenerate

    ppi_state_t                       state, state_nx;
    logic        [PW-1:0]             phase;
    logic        [PW-1:0]             sub;
    logic signed [gp_idata_width-1:0] x_line [T];
    logic signed [gp_odata_width-1:0] y;
    logic                             last_phase;
    logic                             accept;

    assign last_phase = (phase == PW'(L-1));
    assign accept     = i_valid & o_ready;
    assign sub        = gp_phase_rev ? (PW'(L-1) - phase) : phase;

    // Ready opens on the final phase too, so a waiting source chains bursts without a gap.
    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (last_phase) begin
                    o_ready = 1'b1;
                    if (!i_valid) state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_phase <= '0;
            o_sclk  <= 1'b0;
            for (int k = 0; k < T; k++) x_line[k] <= '0;
        end else begin
            state  <= state_nx;
            o_sclk <= accept;
            if (accept) begin
                x_line[0] <= i_data;
                for (int k = 1; k < T; k++) x_line[k] <= x_line[k-1];
                phase <= '0;
            end else if (state == ST_RUN && !last_phase) begin
                phase <= phase + PW'(1);
            end
            o_valid <= (state == ST_RUN);
            if (state == ST_RUN) begin
                o_data  <= y;
                o_phase <= sub;
            end
        end
    end

    filt_ppi_phase_mac #(
        .gp_idata_width         (gp_idata_width),
        .gp_interpolation_factor(L),
        .gp_coeff_length        (gp_coeff_length),
        .gp_coeff_width         (gp_coeff_width),
        .gp_coeffs              (gp_coeffs),
        .gp_taps                (T),
        .gp_odata_width         (gp_odata_width),
        .gp_phase_width         (PW)
    ) u_mac (
        .phase (sub),
        .x_line(x_line),
        .y     (y)
    );

endmodule
